pe_mac_vec: RTL



---
 rtl/pe_mac_vec.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pe_mac_vec.sv
// Multi-lane processing element: LANES neurons share one broadcast activation stream,
// each accumulating a DEPTH-long signed dot product. Optional macro PE_RELU_EN clamps negative results to zero.
module pe_mac_vec #(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter int DEPTH  = 32,
  parameter int FRAC   = 6,
  parameter int LANES  = 2,
  parameter int OUT_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_valid,
  input  logic [LANES*WGT_W-1:0]     w_data,
  output logic                       w_ready,
  input  logic                       w_reload,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [LANES*OUT_W-1:0]     out_data,
  input  logic                       out_ready
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int PRD_W = DATA_W + WGT_W;
  localparam int ACC_W = PRD_W + $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        wcnt;
  logic [CNT_W-1:0]        icnt;
  logic signed [WGT_W-1:0] wmem [LANES][DEPTH];

  logic signed [PRD_W-1:0] prod_p0    [LANES];
  logic signed [ACC_W-1:0] acc_p0     [LANES];
  logic signed [ACC_W-1:0] acc_nxt_p0 [LANES];
  logic signed [OUT_W-1:0] res_p0     [LANES];

  logic                    vld_p1;
  logic [LANES*OUT_W-1:0]  out_p1;

  function automatic logic signed [ACC_W-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
`ifdef PE_RELU_EN
    if (s[ACC_W-1]) s = '0;
`endif
    return s;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return s[OUT_W-1:0];
  endfunction

  assign w_ready   = (state == ST_LOAD);
  assign in_ready  = (state == ST_RUN);
  assign out_valid = vld_p1;
  assign out_data  = out_p1;

  // Stage p0: multiply the broadcast activation by each lane's current weight
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_p0[l]    = in_data * wmem[l][icnt];
      acc_nxt_p0[l] = acc_p0[l] + ACC_W'(prod_p0[l]);
      res_p0[l]     = saturate(requant(acc_nxt_p0[l]));
    end
  end

  // Weight storage is plain data and carries no reset
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && w_valid) begin
      for (int l = 0; l < LANES; l++) begin
        wmem[l][wcnt] <= w_data[l*WGT_W +: WGT_W];
      end
    end
  end

  // Stage p1: control, accumulators and the registered result vector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_LOAD;
      wcnt   <= '0;
      icnt   <= '0;
      vld_p1 <= 1'b0;
      out_p1 <= '0;
      for (int l = 0; l < LANES; l++) acc_p0[l] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (w_valid) begin
            if (wcnt == LAST) begin
              wcnt  <= '0;
              state <= ST_RUN;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          // An accepted activation beat wins over a simultaneous reload request
          if (in_valid) begin
            for (int l = 0; l < LANES; l++) acc_p0[l] <= acc_nxt_p0[l];
            if (icnt == LAST) begin
              icnt   <= '0;
              state  <= ST_OUT;
              vld_p1 <= 1'b1;
              for (int l = 0; l < LANES; l++) out_p1[l*OUT_W +: OUT_W] <= res_p0[l];
            end else begin
              icnt <= icnt + 1'b1;
            end
          end else if (w_reload && icnt == '0) begin
            wcnt  <= '0;
            state <= ST_LOAD;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            vld_p1 <= 1'b0;
            state  <= ST_RUN;
            for (int l = 0; l < LANES; l++) acc_p0[l] <= '0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
